// File: rtl/uartbytes_to_bram.sv
// UART 8N1 receiver that packs bytes MSB-first into BRAM words written to consecutive addresses.
// Define UARTBYTES_TIMEOUT_EN to drop a partial word after TIMEOUT_BAUDS idle bit-times.
module uartbytes_to_bram #(
   parameter int BRAM_WIDTH    = 24,
   parameter int BRAM_DEPTH    = 320*240,
   parameter int BAUD_RATE     = 3000000,
   parameter int CLK_FREQ      = 100000000,
   parameter int TIMEOUT_BAUDS = 64
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          uart_rxd,
   input  logic                          recv_enable_in,
   output logic [$clog2(BRAM_DEPTH)-1:0] wr_addr_out,
   output logic [BRAM_WIDTH-1:0]         wr_data_out,
   output logic                          wr_en_out,
   output logic                          frame_done_out,
   output logic                          frame_err_out,
   output logic                          busy_out
);
   localparam int BYTES = BRAM_WIDTH / 8;
   localparam int CPB   = CLK_FREQ / BAUD_RATE;
   localparam int AW    = $clog2(BRAM_DEPTH);
   localparam int BCW   = $clog2(CPB + 1);
   localparam int NW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0] HALF_M1   = BCW'(CPB / 2 - 1);
   localparam logic [BCW-1:0] FULL_M1   = BCW'(CPB - 1);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(BRAM_DEPTH - 1);
   localparam logic [NW-1:0]  LAST_BYTE = NW'(BYTES - 1);

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;

   rx_state_t         r_state, w_state_nx;
   logic              r_sync1, r_sync2, w_rxs;
   logic [BCW-1:0]    r_bc, w_bc_nx;
   logic [2:0]        r_bit, w_bit_nx;
   logic [7:0]        r_shift, w_shift_nx;
   logic              w_byte_vld, w_ferr_set, r_byte_vld;
   logic [BRAM_WIDTH-1:0] r_word;
   logic [NW-1:0]     r_cnt;
   logic              r_full;
   logic              w_timeout;

   assign w_rxs    = r_sync2;
   assign busy_out = (r_state != R_IDLE) || (r_cnt != '0);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= R_IDLE;
         r_bc    <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_sync1 <= uart_rxd;
         r_sync2 <= r_sync1;
         r_state <= w_state_nx;
         r_bc    <= w_bc_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_bc_nx    = r_bc + 1'b1;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_byte_vld = 1'b0;
      w_ferr_set = 1'b0;
      case (r_state)
         R_IDLE: begin
            w_bc_nx = '0;
            if (!w_rxs) w_state_nx = R_START;
         end
         R_START: begin
            // Re-check the line half a bit in, so short low glitches are ignored silently.
            if (r_bc == HALF_M1) begin
               w_bc_nx    = '0;
               w_bit_nx   = '0;
               w_state_nx = w_rxs ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (r_bc == FULL_M1) begin
               w_bc_nx    = '0;
               w_shift_nx = {w_rxs, r_shift[7:1]};
               w_bit_nx   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nx = R_STOP;
            end
         end
         R_STOP: begin
            if (r_bc == FULL_M1) begin
               w_bc_nx = '0;
               if (w_rxs) begin
                  w_byte_vld = 1'b1;
                  w_state_nx = R_IDLE;
               end else begin
                  w_ferr_set = 1'b1;
                  w_state_nx = R_BREAK;
               end
            end
         end
         R_BREAK: begin
            w_bc_nx = '0;
            if (w_rxs) w_state_nx = R_IDLE;
         end
         default: w_state_nx = R_IDLE;
      endcase
      if (!recv_enable_in) begin
         w_state_nx = R_IDLE;
         w_bc_nx    = '0;
         w_byte_vld = 1'b0;
         w_ferr_set = 1'b0;
      end
   end

`ifdef UARTBYTES_TIMEOUT_EN
   localparam int TOC = TIMEOUT_BAUDS * CPB;
   localparam int TW  = $clog2(TOC + 1);
   logic [TW-1:0] r_idle_cnt;
   logic          w_idle_run;

   assign w_idle_run = (r_cnt != '0) && (r_state == R_IDLE) && !r_byte_vld;
   assign w_timeout  = w_idle_run && (r_idle_cnt == TW'(TOC - 1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                                   r_idle_cnt <= '0;
      else if (!recv_enable_in || !w_idle_run || w_timeout) r_idle_cnt <= '0;
      else                                             r_idle_cnt <= r_idle_cnt + 1'b1;
   end
`else
   // TIMEOUT_BAUDS is never negative, so partial words are never dropped here.
   assign w_timeout = (TIMEOUT_BAUDS < 0);
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_byte_vld     <= 1'b0;
         r_word         <= '0;
         r_cnt          <= '0;
         r_full         <= 1'b0;
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         wr_en_out      <= 1'b0;
         frame_done_out <= 1'b0;
         frame_err_out  <= 1'b0;
      end else if (!recv_enable_in) begin
         r_byte_vld     <= 1'b0;
         r_word         <= '0;
         r_cnt          <= '0;
         r_full         <= 1'b0;
         wr_addr_out    <= '0;
         wr_en_out      <= 1'b0;
         frame_done_out <= 1'b0;
         frame_err_out  <= 1'b0;
      end else begin
         r_byte_vld     <= w_byte_vld;
         r_full         <= 1'b0;
         wr_en_out      <= r_full;
         frame_done_out <= r_full && (wr_addr_out == LAST_ADDR);
         if (w_ferr_set) frame_err_out <= 1'b1;
         if (r_full) wr_data_out <= r_word;
         if (wr_en_out) wr_addr_out <= (wr_addr_out == LAST_ADDR) ? '0 : wr_addr_out + 1'b1;
         if (r_byte_vld) begin
            r_word <= {r_word[BRAM_WIDTH-9:0], r_shift};
            if (r_cnt == LAST_BYTE) begin
               r_cnt  <= '0;
               r_full <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else if (w_timeout) begin
            r_cnt  <= '0;
            r_word <= '0;
         end
      end
   end
endmodule

// File: tb/tb_uartbytes_to_bram.sv
// Bench for uartbytes_to_bram: serial stimulus checked against a byte-list reference model.
`timescale 1ns/1ps
module tb_uartbytes_to_bram;
   localparam int CPB = 33;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b1;
   logic        uart_rxd = 1'b1;
   logic        recv_enable_in = 1'b1;
   logic [1:0]  wr_addr_out;
   logic [23:0] wr_data_out;
   logic        wr_en_out, frame_done_out, frame_err_out, busy_out;

   int total = 0;
   int bad = 0;
   logic [26:0] got_q[$];
   logic [26:0] exp_q[$];
   logic [7:0]  part[$];
   int   m_addr = 0;
   logic m_err = 1'b0;
   int   stray_done = 0;
   int   long_pulse = 0;
   logic prev_we = 1'b0;

   uartbytes_to_bram #(
      .BRAM_WIDTH(24), .BRAM_DEPTH(4), .BAUD_RATE(3000000),
      .CLK_FREQ(100000000), .TIMEOUT_BAUDS(64)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .uart_rxd(uart_rxd),
      .recv_enable_in(recv_enable_in), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
      .frame_done_out(frame_done_out), .frame_err_out(frame_err_out),
      .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (wr_en_out) got_q.push_back({wr_addr_out, wr_data_out, frame_done_out});
      if (frame_done_out && !wr_en_out) stray_done++;
      if (wr_en_out && prev_we) long_pulse++;
      prev_we = wr_en_out;
   end

   // Reference model: bytes accumulate in a list; every third byte yields one write.
   task automatic m_byte(input logic [7:0] b);
      logic [1:0] a;
      part.push_back(b);
      if (part.size() == 3) begin
         a = m_addr[1:0];
         exp_q.push_back({a, part[0], part[1], part[2], a == 2'd3});
         part.delete();
         m_addr = (m_addr + 1) % 4;
      end
   endtask

   task automatic m_clear();
      part.delete();
      m_addr = 0;
      m_err  = 1'b0;
   endtask

   task automatic line_bit(input logic v);
      uart_rxd = v;
      repeat (CPB) @(negedge clk_in);
   endtask

   task automatic tx(input logic [7:0] b, input logic ok);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(ok);
      if (ok) m_byte(b);
      else begin
         m_err = 1'b1;
         line_bit(1'b1);
      end
      repeat (4) @(negedge clk_in);
   endtask

   task automatic disable_rx();
      recv_enable_in = 1'b0;
      repeat (3) @(negedge clk_in);
      recv_enable_in = 1'b1;
      @(negedge clk_in);
      m_clear();
   endtask

   task automatic test_reset();
      #2 rst_n_in = 1'b0;
      repeat (3) @(negedge clk_in);
      total++;
      if ({wr_addr_out, wr_data_out, wr_en_out, frame_done_out, frame_err_out, busy_out} !== 30'd0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0",
            {wr_addr_out, wr_data_out, wr_en_out, frame_done_out, frame_err_out, busy_out});
      end
      rst_n_in = 1'b1;
      repeat (5) @(negedge clk_in);
      total++;
      if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_out); end
      total++;
      if (wr_addr_out !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", wr_addr_out); end
      got_q.delete();
   endtask

   task automatic test_single();
      tx(8'h12, 1'b1); tx(8'h34, 1'b1); tx(8'h56, 1'b1);
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_q.size()); end
      total++;
      if (got_q.size() > 0 && got_q[0] !== {2'd0, 24'h123456, 1'b0}) begin
         bad++; $display("FAIL single_write got=%h want=%h", got_q[0], {2'd0, 24'h123456, 1'b0});
      end
      total++;
      if (wr_addr_out !== 2'd1) begin bad++; $display("FAIL single_addr got=%0d want=1", wr_addr_out); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_frame();
      disable_rx();
      got_q.delete();
      for (int i = 0; i < 12; i++) tx(8'(i), 1'b1);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL frame_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL frame_wr%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      total++;
      if (wr_addr_out !== 2'd0) begin bad++; $display("FAIL frame_addr_wrap got=%0d want=0", wr_addr_out); end
      total++;
      if (stray_done != 0 || long_pulse != 0) begin
         bad++; $display("FAIL frame_pulses got=%0d/%0d want=0/0", stray_done, long_pulse);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_framing_err();
      tx(8'h12, 1'b1); tx(8'hE7, 1'b0); tx(8'h34, 1'b1); tx(8'h56, 1'b1);
      total++;
      if (frame_err_out !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b want=1", frame_err_out); end
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL ferr_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ferr_wr%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_disable();
      tx(8'h12, 1'b1);
      total++;
      if (busy_out !== 1'b1) begin bad++; $display("FAIL dis_busy_partial got=%b want=1", busy_out); end
      recv_enable_in = 1'b0;
      repeat (2) @(negedge clk_in);
      total++;
      if ({wr_addr_out, busy_out, frame_err_out, wr_en_out} !== 5'd0) begin
         bad++; $display("FAIL dis_cleared got=%b want=0", {wr_addr_out, busy_out, frame_err_out, wr_en_out});
      end
      recv_enable_in = 1'b1;
      @(negedge clk_in);
      m_clear();
      tx(8'hAA, 1'b1); tx(8'hBB, 1'b1); tx(8'hCC, 1'b1);
      total++;
      if (got_q.size() != 1 || got_q[0] !== {2'd0, 24'hAABBCC, 1'b0}) begin
         bad++; $display("FAIL dis_write got=%h (n=%0d) want=%h", (got_q.size() > 0) ? got_q[0] : 27'h0,
            got_q.size(), {2'd0, 24'hAABBCC, 1'b0});
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_glitch();
      uart_rxd = 1'b0;
      repeat (8) @(negedge clk_in);
      total++;
      if (busy_out !== 1'b1) begin bad++; $display("FAIL glitch_busy_mid got=%b want=1", busy_out); end
      repeat (2) @(negedge clk_in);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk_in);
      total++;
      if ({busy_out, frame_err_out} !== 2'b00) begin
         bad++; $display("FAIL glitch_idle got=%b want=00", {busy_out, frame_err_out});
      end
      total++;
      if (got_q.size() != 0) begin bad++; $display("FAIL glitch_writes got=%0d want=0", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      tx(8'h12, 1'b1);
      uart_rxd = 1'b0;
      repeat (3 * CPB) @(negedge clk_in);
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      total++;
      if ({wr_addr_out, wr_data_out, wr_en_out, frame_done_out, frame_err_out, busy_out} !== 30'd0) begin
         bad++; $display("FAIL rstmid_outputs got=%h want=0",
            {wr_addr_out, wr_data_out, wr_en_out, frame_done_out, frame_err_out, busy_out});
      end
      uart_rxd = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_n_in = 1'b1;
      m_clear();
      repeat (5) @(negedge clk_in);
      tx(8'hAA, 1'b1); tx(8'hBB, 1'b1); tx(8'hCC, 1'b1);
      total++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         bad++; $display("FAIL rstmid_write got=%h (n=%0d) want=%h", (got_q.size() > 0) ? got_q[0] : 27'h0,
            got_q.size(), exp_q[0]);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      logic want_busy;
      disable_rx();
      tx(8'h99, 1'b1);
      repeat (70 * CPB) @(negedge clk_in);
`ifdef UARTBYTES_TIMEOUT_EN
      part.delete();
`endif
      want_busy = (part.size() != 0);
      total++;
      if (busy_out !== want_busy) begin bad++; $display("FAIL timeout_busy got=%b want=%b", busy_out, want_busy); end
      tx(8'h12, 1'b1); tx(8'h34, 1'b1); tx(8'h56, 1'b1);
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL timeout_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL timeout_wr%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       ok;
      logic       want_busy;
      disable_rx();
      got_q.delete();
      for (int n = 0; n < 30; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         tx(b, ok);
         repeat ($urandom_range(0, 40)) @(negedge clk_in);
      end
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++; $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_wr%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      want_busy = (part.size() != 0);
      total++;
      if ({frame_err_out, busy_out, wr_addr_out} !== {m_err, want_busy, m_addr[1:0]}) begin
         bad++; $display("FAIL random_state got=%b want=%b", {frame_err_out, busy_out, wr_addr_out},
            {m_err, want_busy, m_addr[1:0]});
      end
      total++;
      if (stray_done != 0 || long_pulse != 0) begin
         bad++; $display("FAIL random_pulses got=%0d/%0d want=0/0", stray_done, long_pulse);
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_frame();
      test_framing_err();
      test_disable();
      test_glitch();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
